// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the control stage: opcodes, ALU op codes
// and the registered control bundle.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_ITYPE   = 3'b001,
    ALU_RTYPE   = 3'b010,
    ALU_BRANCH  = 3'b011,
    ALU_LUI     = 3'b100,
    ALU_INVALID = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    link;
    logic    a_pc;
    logic    word_op;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Bundle used for anything that does not decode: only illegal/INVALID set.
  function automatic ctrl_t ctrl_illegal();
    ctrl_t c;
    c         = '0;
    c.illegal = 1'b1;
    c.alu_op  = ALU_INVALID;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Combinational opcode decoder: instruction word -> control bundle plus
// source-register usage flags for the load-use hazard check.
module ctrl_dec
  import ctrl_pkg::*;
#(
  parameter int EN_RV64W = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic bad;

  always_comb begin
    ctrl     = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    bad      = 1'b0;
    if (instr[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_R: begin
          ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_RTYPE;
          uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        OPC_I: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ITYPE;
          uses_rs1 = 1'b1;
        end
        OPC_LOAD: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
          ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
          uses_rs1 = 1'b1;
        end
        OPC_STORE: begin
          ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
          uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        OPC_BRANCH: begin
          ctrl.branch = 1'b1; ctrl.alu_op = ALU_BRANCH;
          uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        OPC_JAL: begin
          ctrl.reg_write = 1'b1; ctrl.jump = 1'b1;
          ctrl.link = 1'b1; ctrl.a_pc = 1'b1;
        end
        OPC_JALR: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
          ctrl.jump = 1'b1; ctrl.link = 1'b1;
          uses_rs1 = 1'b1;
        end
        OPC_LUI: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_LUI;
        end
        OPC_AUIPC: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.a_pc = 1'b1;
        end
        OPC_IMM32: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ITYPE;
          ctrl.word_op = 1'b1;
          uses_rs1 = 1'b1;
          bad = (EN_RV64W == 0);
        end
        OPC_OP32: begin
          ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_RTYPE; ctrl.word_op = 1'b1;
          uses_rs1 = 1'b1; uses_rs2 = 1'b1;
          bad = (EN_RV64W == 0);
        end
        default: bad = 1'b1;
      endcase
    end
    // Illegal words still flow downstream but must not look like they read regs.
    if (bad) begin
      ctrl     = ctrl_illegal();
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_stage.sv
// Single-slot decode/control pipeline stage with load-use stall, flush and
// saturating stall / illegal-instruction counters.
module ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int EN_RV64W = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_t            out_ctrl,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_t      dec_ctrl;
  logic       uses_rs1, uses_rs2;
  logic       hazard, accept;
  logic [4:0] rd, rs1, rs2;

  assign rd  = in_instr[11:7];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  ctrl_dec #(.EN_RV64W(EN_RV64W)) u_dec (
    .instr    (in_instr),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // A load still in the slot cannot forward; its consumer waits one cycle.
  assign hazard = out_valid && out_ctrl.mem_read && (out_rd != 5'd0) &&
                  ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd));
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ctrl  <= dec_ctrl;
      out_rd    <= rd;
      out_rs1   <= rs1;
      out_rs2   <= rs2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      if (in_valid && hazard && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (accept && dec_ctrl.illegal && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_stage.sv
// Randomized + directed bench for ctrl_stage: two instances (RV64W on with
// 16-bit counters, RV64W off with 4-bit counters) against a cycle model.
module tb_ctrl_stage;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        rdy0, rdy1, ov0, ov1;
  ctrl_t       ctl0, ctl1;
  logic [4:0]  rd0, rs10, rs20, rd1, rs11, rs21;
  logic [15:0] sc0, ic0;
  logic [3:0]  sc1, ic1;

  int vectors = 0;
  int errors  = 0;

  bit          m_vld[2];
  logic [31:0] m_ins[2];
  int          m_sc[2], m_ic[2];
  int          sat[2] = '{65535, 15};

  always #5 clk = ~clk;

  ctrl_stage u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_instr(in_instr), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_ctrl(ctl0), .out_rd(rd0), .out_rs1(rs10), .out_rs2(rs20),
    .stall_cnt(sc0), .illegal_cnt(ic0)
  );

  ctrl_stage #(.EN_RV64W(0), .CNT_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_instr(in_instr), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_ctrl(ctl1), .out_rd(rd1), .out_rs1(rs11), .out_rs2(rs21),
    .stall_cnt(sc1), .illegal_cnt(ic1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the opcode table. Returns
  // {uses_rs1, uses_rs2, rw, as, mr, m2r, mw, br, jump, link, a_pc, word, ill, alu_op[2:0]}.
  function automatic logic [15:0] ref_dec(input logic [31:0] i, input bit en64);
    logic rw, as, mr, m2r, mw, br, j, l, ap, wo, il, u1, u2;
    logic [2:0] op;
    {rw, as, mr, m2r, mw, br, j, l, ap, wo, il, u1, u2} = '0;
    op = 3'd0;
    if (i[1:0] != 2'b11) il = 1'b1;
    else case (i[6:0])
      7'b0110011: begin rw = 1; op = 3'd2; u1 = 1; u2 = 1; end
      7'b0010011: begin rw = 1; as = 1; op = 3'd1; u1 = 1; end
      7'b0000011: begin rw = 1; as = 1; mr = 1; m2r = 1; u1 = 1; end
      7'b0100011: begin as = 1; mw = 1; u1 = 1; u2 = 1; end
      7'b1100011: begin br = 1; op = 3'd3; u1 = 1; u2 = 1; end
      7'b1101111: begin rw = 1; j = 1; l = 1; ap = 1; end
      7'b1100111: begin rw = 1; as = 1; j = 1; l = 1; u1 = 1; end
      7'b0110111: begin rw = 1; as = 1; op = 3'd4; end
      7'b0010111: begin rw = 1; as = 1; ap = 1; end
      7'b0011011: if (en64) begin rw = 1; as = 1; op = 3'd1; wo = 1; u1 = 1; end
                  else il = 1;
      7'b0111011: if (en64) begin rw = 1; op = 3'd2; wo = 1; u1 = 1; u2 = 1; end
                  else il = 1;
      default: il = 1;
    endcase
    if (il) op = 3'd7;
    return {u1, u2, rw, as, mr, m2r, mw, br, j, l, ap, wo, il, op};
  endfunction

  // Apply one cycle of inputs, check both DUTs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [15:0] hd, nd;
      logic [4:0]  hrd;
      bit          haz, rdy_e, acc;
      hd  = ref_dec(m_ins[d], d == 0);
      nd  = ref_dec(ins, d == 0);
      hrd = m_ins[d][11:7];
      haz = m_vld[d] && hd[11] && hrd != 5'd0 &&
            ((nd[15] && ins[19:15] == hrd) || (nd[14] && ins[24:20] == hrd));
      rdy_e = (!m_vld[d] || ordy) && !haz && !fl;
      acc   = v && rdy_e;
      chk($sformatf("in_ready[%0d]", d), d ? 32'(rdy1) : 32'(rdy0), 32'(rdy_e));
      chk($sformatf("out_valid[%0d]", d), d ? 32'(ov1) : 32'(ov0), 32'(m_vld[d]));
      if (m_vld[d]) begin
        chk($sformatf("out_ctrl[%0d]", d), d ? 32'(ctl1) : 32'(ctl0), 32'(hd[13:0]));
        chk($sformatf("out_rd[%0d]", d), d ? 32'(rd1) : 32'(rd0), 32'(hrd));
        chk($sformatf("out_rs1[%0d]", d), d ? 32'(rs11) : 32'(rs10), 32'(m_ins[d][19:15]));
        chk($sformatf("out_rs2[%0d]", d), d ? 32'(rs21) : 32'(rs20), 32'(m_ins[d][24:20]));
      end
      chk($sformatf("stall_cnt[%0d]", d), d ? 32'(sc1) : 32'(sc0), 32'(m_sc[d]));
      chk($sformatf("illegal_cnt[%0d]", d), d ? 32'(ic1) : 32'(ic0), 32'(m_ic[d]));
      if (v && haz && m_sc[d] < sat[d]) m_sc[d]++;
      if (acc && nd[3] && m_ic[d] < sat[d]) m_ic[d]++;
      if (fl) m_vld[d] = 0;
      else if (acc) begin m_vld[d] = 1; m_ins[d] = ins; end
      else if (ordy) m_vld[d] = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", {30'd0, ov1, ov0}, 32'd0);
    chk("rst_out_ctrl", {4'd0, ctl1, ctl0}, 32'd0);
    chk("rst_regs", {2'd0, rd1, rs11, rs21, rd0, rs10, rs20}, 32'd0);
    chk("rst_cnt", {sc1, ic1, sc0[11:0], ic0[11:0]}, 32'd0);
    chk("rst_cnt_hi", {sc0[15:12], ic0[15:12]}, 32'd0);
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 0; m_ins[d] = '0; m_sc[d] = 0; m_ic[d] = 0;
    end
  endtask

  // Asynchronous reset dropped in between clock edges.
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1 chk_reset_state();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [12];
    logic [31:0] w;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b0110111, 7'b0010111, 7'b0011011, 7'b0111011, 7'b1111111};
    w = $urandom;
    w[6:0]   = opcs[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  initial begin
    #1 chk_reset_state();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2
    step(1, 32'h002081B3, 1, 0);
    step(0, 32'h0, 1, 0);
    // load-use: one bubble, one stall count
    step(1, 32'h0000B283, 1, 0);
    step(1, 32'h00128333, 1, 0);
    step(1, 32'h00128333, 1, 0);
    step(0, 32'h0, 1, 0);
    chk("ld_use_stall", 32'(sc0), 32'd1);
    // load to x0 never stalls
    step(1, 32'h0000B003, 1, 0);
    step(1, 32'h00000033, 1, 0);
    step(0, 32'h0, 1, 0);
    chk("ld_x0_nostall", 32'(sc0), 32'd1);
    // illegal opcode, then OP-32 (illegal only without RV64W)
    step(1, 32'h0000007F, 1, 0);
    step(1, 32'h003100BB, 1, 0);
    step(0, 32'h0, 1, 0);
    chk("illegal_cnt64", 32'(ic0), 32'd1);
    chk("illegal_cnt32", 32'(ic1), 32'd2);
    // backpressure then flush
    step(1, 32'h002081B3, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 32'h00418233, 0, 0);
    step(1, 32'h00418233, 0, 1);
    step(0, 32'h0, 1, 0);

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) reset_mid();
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);
    end

    // Held load with a dependent consumer: stalls every cycle, 4-bit counter saturates.
    step(0, 32'h0, 1, 0);
    step(1, 32'h0000B283, 1, 0);
    for (int k = 0; k < 20; k++) step(1, 32'h00128333, 0, 0);
    chk("stall_sat32", 32'(sc1), 32'd15);
    step(1, 32'h00128333, 0, 0);
    chk("stall_sat32_hold", 32'(sc1), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_stage.md
CTRL_STAGE -- requirements
Module: ctrl_stage

Interface
REQ-001 SHALL have parameter EN_RV64W, default 1, enabling the OP-IMM-32 (0011011) and OP-32 (0111011) opcodes; when 0 both decode as illegal.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state rises on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_instr is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  the stage accepts in_instr this cycle.
REQ-007 SHALL have port in_instr  input  32  raw instruction word.
REQ-008 SHALL have port flush  input  1  synchronous kill of the held and incoming instruction.
REQ-009 SHALL have port out_valid  output  1  out_ctrl, out_rd, out_rs1 and out_rs2 are valid.
REQ-010 SHALL have port out_ready  input  1  the downstream stage consumes the output this cycle.
REQ-011 SHALL have port out_ctrl  output  CTRL_W  registered control bundle ctrl_t.
REQ-012 SHALL have ports out_rd, out_rs1 and out_rs2  output  5 each  register indices taken from instr[11:7], [19:15] and [24:20].
REQ-013 SHALL have ports stall_cnt and illegal_cnt  output  CNT_W each  saturating event counters.

Function
REQ-014 ctrl_t fields SHALL be: reg_write, alu_src, mem_read, mem_to_reg, mem_write, branch, jump, link, a_pc, word_op, illegal, and alu_op[2:0].
REQ-015 alu_op encoding SHALL be: ADD=000, ITYPE=001, RTYPE=010, BRANCH=011, LUI=100, INVALID=111.
REQ-016 Decode SHALL assert these fields per opcode (unlisted fields 0):
- R (0110011): rw, RTYPE.
- I (0010011): rw, as, ITYPE.
- LOAD (0000011): rw, as, mr, m2r, ADD.
- STORE (0100011): as, mw, ADD.
- BRANCH (1100011): br, BRANCH.
- JAL (1101111): rw, jump, link, a_pc, ADD.
- JALR (1100111): rw, as, jump, link, ADD.
- LUI (0110111): rw, as, LUI.
- AUIPC (0010111): rw, as, a_pc, ADD.
- OP-IMM-32: as I plus word_op.
- OP-32: as R plus word_op.
REQ-017 Any other opcode, or instr[1:0]!=2'b11, SHALL set illegal=1 and alu_op=INVALID with all other fields 0; the instruction still flows downstream.
REQ-018 The stage SHALL be a single registered slot with a latency of 1 cycle from acceptance to out_valid.
REQ-019 Handshake: an input is accepted when in_valid && in_ready; the output transfers when out_valid && out_ready.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-021 hazard SHALL be asserted when out_valid && out_ctrl.mem_read && out_rd!=0 && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)).
REQ-022 uses_rs1 SHALL be set for R, I, LOAD, STORE, BRANCH, JALR, OP-IMM-32 and OP-32.
REQ-023 uses_rs2 SHALL be set for R, STORE, BRANCH and OP-32.
REQ-024 Under hazard, an out_ready transfer SHALL leave out_valid=0 (one bubble), and the dependent instruction SHALL be accepted in the next cycle.
REQ-025 With out_valid=0 there is no hazard, so the input is accepted immediately.
REQ-026 While out_valid && !out_ready, out_ctrl, out_rd, out_rs1 and out_rs2 SHALL hold stable.
REQ-027 flush SHALL force out_valid=0 on the next edge, discard any input presented that cycle, and take priority over all other updates.
REQ-028 stall_cnt SHALL increment each cycle that in_valid && hazard holds, saturating at all-ones.
REQ-029 illegal_cnt SHALL increment on each accepted illegal instruction, saturating at all-ones.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately clear out_valid, out_ctrl, out_rd, out_rs1, out_rs2, stall_cnt and illegal_cnt to 0.
REQ-031 in_ready SHALL be 1 once rst_n deasserts.
REQ-032 A reset mid-transfer SHALL drop the held instruction with no partial output.

Structure
REQ-033 Package ctrl_pkg SHALL hold the opcode localparams, the alu_op encodings, the ctrl_t packed struct and CTRL_W.
REQ-034 A purely combinational sub-module ctrl_dec SHALL map in_instr to ctrl_t, uses_rs1 and uses_rs2; ctrl_stage SHALL hold the register slot, hazard logic and counters.

Verification
REQ-035 Accept 0x002081B3 (add x3,x1,x2) -> out_valid next cycle; out_ctrl rw=1, alu_op=010; out_rd=3.
REQ-036 Send 0x0000B283 (ld x5,0(x1)) then 0x00128333 (add x6,x5,x1) with out_ready=1 -> exactly one bubble cycle and stall_cnt=1.
REQ-037 Send 0x0000B003 (ld x0) then a dependent instruction reading x0 -> no bubble and stall_cnt=0.
REQ-038 Send 0x0000007F -> illegal=1, alu_op=111, rw=mw=0, illegal_cnt=1; with EN_RV64W=0, 0x003100BB -> illegal=1.
REQ-039 Hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0; then flush=1 -> out_valid=0 next cycle and the input is dropped.
REQ-040 Assert rst_n=0 mid-stream -> all outputs 0 asynchronously; force stall_cnt to 0xFFFF and stall once more -> it stays at 0xFFFF.
